// File: rtl/pred_writeback_unit.sv
// pred_writeback_unit
//   Predicate writeback stage in front of predicate_register_block.
//   Per-warp predicate results (LANES lanes, 1 bit each) enter through a
//   valid/ready handshake and are held in an in-order FIFO of DEPTH entries.
//   One write per granted cycle is drained onto the register block write port.
//   A combinational pending-write query supports predicate RAW hazard checks.
//
// Optional feature macro: PRED_WB_BYPASS_EN
//   When defined, a result arriving while the FIFO is empty and the write port
//   is granted is written in the same cycle without being enqueued.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  result handshake
//   in_warp, in_preg   destination warp / predicate register
//   in_mask, in_data   active-lane mask and per-lane predicate value
//   pr_wr_req          head entry (or bypass) wants the write port
//   pr_wr_gnt          write port granted this cycle
//   pr_write_en        per-lane write enables to the register block
//   pr_waddr, pr_wdata write address / data to the register block
//   pr_warp_selector   warp for this write
//   hz_warp, hz_preg   hazard query target
//   hz_pending         some queued write targets (hz_warp, hz_preg)
//   count              current FIFO occupancy
module pred_writeback_unit #(
  parameter int DEPTH  = 4,
  parameter int LANES  = 16,
  parameter int WARP_W = 4,
  parameter int PREG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WARP_W-1:0]        in_warp,
  input  logic [PREG_W-1:0]        in_preg,
  input  logic [LANES-1:0]         in_mask,
  input  logic [LANES-1:0]         in_data,
  output logic                     pr_wr_req,
  input  logic                     pr_wr_gnt,
  output logic [LANES-1:0]         pr_write_en,
  output logic [PREG_W-1:0]        pr_waddr,
  output logic [LANES-1:0]         pr_wdata,
  output logic [WARP_W-1:0]        pr_warp_selector,
  input  logic [WARP_W-1:0]        hz_warp,
  input  logic [PREG_W-1:0]        hz_preg,
  output logic                     hz_pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic [DEPTH-1:0]  e_valid;
  logic [WARP_W-1:0] e_warp [DEPTH];
  logic [PREG_W-1:0] e_preg [DEPTH];
  logic [LANES-1:0]  e_mask [DEPTH];
  logic [LANES-1:0]  e_data [DEPTH];

  logic bypass;
  logic push;
  logic pop;
  logic not_empty;

  assign count     = cnt;
  assign not_empty = (cnt != '0);
  assign in_ready  = (cnt < CW'(DEPTH));

`ifdef PRED_WB_BYPASS_EN
  assign bypass = !rst && !not_empty && in_valid && (in_mask != '0) && pr_wr_gnt;
`else
  assign bypass = 1'b0;
`endif

  // Zero-mask results are accepted but never allocate an entry.
  assign push = in_valid && in_ready && (in_mask != '0) && !bypass;
  assign pop  = not_empty && pr_wr_gnt && !rst;

  always_comb begin
    pr_wr_req        = not_empty;
    pr_write_en      = '0;
    pr_waddr         = '0;
    pr_wdata         = '0;
    pr_warp_selector = '0;
    if (bypass) begin
      pr_wr_req        = 1'b1;
      pr_write_en      = in_mask;
      pr_waddr         = in_preg;
      pr_wdata         = in_data;
      pr_warp_selector = in_warp;
    end else if (not_empty) begin
      pr_waddr         = e_preg[rptr];
      pr_wdata         = e_data[rptr];
      pr_warp_selector = e_warp[rptr];
      if (pop) pr_write_en = e_mask[rptr];
    end
  end

  always_comb begin
    hz_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (e_valid[i] && (e_warp[i] == hz_warp) && (e_preg[i] == hz_preg))
        hz_pending = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      e_valid <= '0;
    end else begin
      // Push and pop never address the same slot: push needs a free slot,
      // pop needs an occupied one.
      if (push) begin
        e_warp[wptr]  <= in_warp;
        e_preg[wptr]  <= in_preg;
        e_mask[wptr]  <= in_mask;
        e_data[wptr]  <= in_data;
        e_valid[wptr] <= 1'b1;
        wptr          <= wptr + 1'b1;
      end
      if (pop) begin
        e_valid[rptr] <= 1'b0;
        rptr          <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pred_writeback_unit.sv
// tb_pred_writeback_unit
//   Self-checking bench for pred_writeback_unit. A queue-based reference model
//   predicts every output each cycle; directed sequences cover the documented
//   scenarios and a randomized phase covers general traffic.
module tb_pred_writeback_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_warp;
  logic [3:0]  in_preg;
  logic [15:0] in_mask;
  logic [15:0] in_data;
  logic        pr_wr_req;
  logic        pr_wr_gnt;
  logic [15:0] pr_write_en;
  logic [3:0]  pr_waddr;
  logic [15:0] pr_wdata;
  logic [3:0]  pr_warp_selector;
  logic [3:0]  hz_warp;
  logic [3:0]  hz_preg;
  logic        hz_pending;
  logic [2:0]  count;

  pred_writeback_unit #(.DEPTH(DEPTH), .LANES(16), .WARP_W(4), .PREG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_warp(in_warp), .in_preg(in_preg), .in_mask(in_mask), .in_data(in_data),
    .pr_wr_req(pr_wr_req), .pr_wr_gnt(pr_wr_gnt),
    .pr_write_en(pr_write_en), .pr_waddr(pr_waddr), .pr_wdata(pr_wdata),
    .pr_warp_selector(pr_warp_selector),
    .hz_warp(hz_warp), .hz_preg(hz_preg), .hz_pending(hz_pending),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  warp;
    logic [3:0]  preg;
    logic [15:0] mask;
    logic [15:0] data;
  } ent_t;

  ent_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check all outputs against the model for the inputs currently driven,
  // then advance one clock and update the model.
  task automatic tick();
    logic        byp;
    logic        e_ready, e_req, e_hz;
    logic [15:0] e_we, e_wdata;
    logic [3:0]  e_waddr, e_warp;
    #1;
    byp = 1'b0;
`ifdef PRED_WB_BYPASS_EN
    byp = !rst && q.size() == 0 && in_valid && in_mask != 0 && pr_wr_gnt;
`endif
    e_ready = q.size() < DEPTH;
    e_req   = byp || q.size() != 0;
    e_we = '0; e_wdata = '0; e_waddr = '0; e_warp = '0;
    if (byp) begin
      e_we = in_mask; e_wdata = in_data; e_waddr = in_preg; e_warp = in_warp;
    end else if (q.size() != 0) begin
      e_wdata = q[0].data; e_waddr = q[0].preg; e_warp = q[0].warp;
      if (pr_wr_gnt && !rst) e_we = q[0].mask;
    end
    e_hz = 1'b0;
    foreach (q[i]) if (q[i].warp == hz_warp && q[i].preg == hz_preg) e_hz = 1'b1;

    chk("in_ready",  32'(in_ready),         32'(e_ready));
    chk("wr_req",    32'(pr_wr_req),        32'(e_req));
    chk("write_en",  32'(pr_write_en),      32'(e_we));
    chk("waddr",     32'(pr_waddr),         32'(e_waddr));
    chk("wdata",     32'(pr_wdata),         32'(e_wdata));
    chk("warp_sel",  32'(pr_warp_selector), 32'(e_warp));
    chk("hz",        32'(hz_pending),       32'(e_hz));
    chk("count",     32'(count),            32'(q.size()));

    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() != 0 && pr_wr_gnt) void'(q.pop_front());
      if (in_valid && e_ready && in_mask != 0 && !byp)
        q.push_back('{warp: in_warp, preg: in_preg, mask: in_mask, data: in_data});
    end
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [3:0] w, input logic [3:0] p,
                        input logic [15:0] m, input logic [15:0] d, input logic g);
    in_valid = v; in_warp = w; in_preg = p; in_mask = m; in_data = d; pr_wr_gnt = g;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0);
    hz_warp = '0; hz_preg = '0;
    @(negedge clk);

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_req",   32'(pr_wr_req), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    tick();

    // Single write with grant in the following cycle
    set_in(1'b1, 4'd3, 4'd5, 16'hFFFF, 16'hA5A5, 1'b0);
    tick();
    set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1);
    #1;
    chk("single_we",    32'(pr_write_en), 32'h0000FFFF);
    chk("single_addr",  32'(pr_waddr), 32'd5);
    chk("single_warp",  32'(pr_warp_selector), 32'd3);
    chk("single_data",  32'(pr_wdata), 32'h0000A5A5);
    tick();
    tick();

    // Fill, backpressure, drain in order
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 4'(i), 4'(i + 8), 16'h1 << i, 16'(i * 16'h1111), 1'b0);
      tick();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    set_in(1'b1, 4'd9, 4'd9, 16'hFFFF, 16'h0, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 6; i++) tick();

    // Hazard query
    set_in(1'b1, 4'd7, 4'd2, 16'h000F, 16'h0003, 1'b0);
    tick();
    set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0);
    hz_warp = 4'd7; hz_preg = 4'd2; #1;
    chk("hz_hit", 32'(hz_pending), 32'd1);
    tick();
    hz_preg = 4'd3; #1;
    chk("hz_miss", 32'(hz_pending), 32'd0);
    tick();
    hz_preg = 4'd2; pr_wr_gnt = 1'b1; #1;
    chk("hz_popcycle", 32'(hz_pending), 32'd1);
    tick();
    pr_wr_gnt = 1'b0; #1;
    chk("hz_after_pop", 32'(hz_pending), 32'd0);
    tick();

    // Mask handling
    set_in(1'b1, 4'd1, 4'd1, 16'h0000, 16'hFFFF, 1'b0);
    tick();
    chk("zero_mask_count", 32'(count), 32'd0);
    set_in(1'b1, 4'd1, 4'd1, 16'h00F0, 16'hFFFF, 1'b0);
    tick();
    set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1);
    #1;
    chk("partial_we", 32'(pr_write_en), 32'h000000F0);
    tick();

    // Stress: simultaneous push/pop across pointer wrap
    pr_wr_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 4'($urandom), 4'($urandom), 16'($urandom) | 16'h1, 16'($urandom), 1'b0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 4'($urandom), 4'($urandom), 16'($urandom) | 16'h1, 16'($urandom), 1'b1);
      tick();
      chk("stress_count", 32'(count), 32'd3);
    end

    // Reset with queued entries: no write in the reset cycle
    set_in(1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1);
    rst = 1'b1; #1;
    chk("rst_no_write", 32'(pr_write_en), 32'd0);
    tick();
    rst = 1'b0; pr_wr_gnt = 1'b0; #1;
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_req",   32'(pr_wr_req), 32'd0);
    tick();

`ifdef PRED_WB_BYPASS_EN
    set_in(1'b1, 4'd6, 4'd4, 16'h3C3C, 16'h1234, 1'b1);
    #1;
    chk("bypass_we", 32'(pr_write_en), 32'h00003C3C);
    tick();
    chk("bypass_count", 32'(count), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom), 16'($urandom),
             ($urandom_range(0, 2) == 0));
      hz_warp = 4'($urandom_range(0, 3));
      hz_preg = 4'($urandom_range(0, 3));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pred_writeback_unit.md
Name: pred_writeback_unit

Overview:
Writeback stage that sits directly upstream of predicate_register_block. It accepts per-warp predicate results (16 lanes, 1 bit each) from the compare/execute pipeline through a valid/ready handshake and buffers them in a small in-order FIFO. It drains one write per granted cycle onto the register block's write port (write_en, waddr, wdata_0..15, warp_selector). It also exposes a pending-write query that issue logic uses for predicate RAW hazard detection.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
LANES, 16, lanes per warp; fixed at 16 to match the register block
WARP_W, 4, warp id width (16 warps)
PREG_W, 4, predicate register address width (16 registers)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  result valid
in_ready  out  1  unit can accept a result
in_warp  in  WARP_W  destination warp
in_preg  in  PREG_W  destination predicate register
in_mask  in  LANES  active-lane mask; bit i enables lane i
in_data  in  LANES  predicate value per lane
pr_wr_req  out  1  head entry wants the register-block write port
pr_wr_gnt  in  1  issue stage grants the write port (and warp_selector) this cycle
pr_write_en  out  LANES  to register block write_en
pr_waddr  out  PREG_W  to register block waddr
pr_wdata  out  LANES  bit i goes to wdata_i
pr_warp_selector  out  WARP_W  warp for this write; the top level muxes it onto warp_selector when pr_wr_gnt=1
hz_warp  in  WARP_W  hazard query warp
hz_preg  in  PREG_W  hazard query register
hz_pending  out  1  a queued write targets (hz_warp, hz_preg)
count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=1 at posedge): read/write pointers = 0, count = 0, all entry valid bits = 0.
  - Consequences: in_ready=1, pr_wr_req=0, pr_write_en=0, pr_waddr=0, pr_wdata=0, pr_warp_selector=0, hz_pending=0.
  - Reset mid-operation discards all queued entries; no write is issued in the reset cycle.
- Push:
  - Occurs when in_valid && in_ready && in_mask != 0.
  - Stores {warp, preg, mask, data} at wptr; wptr wraps modulo DEPTH.
  - A result with in_mask == 0 is accepted and dropped: it does not allocate an entry or change count.
- in_ready = (count < DEPTH).
  - Combinational from registered state only; it does not depend on pop in the same cycle.
  - When full, a same-cycle pop does not open a slot until the next cycle.
- Head outputs:
  - pr_wr_req = (count != 0).
  - pr_waddr, pr_wdata and pr_warp_selector show the head entry whenever count != 0; they are 0 when empty.
  - pr_write_en = head.mask when pr_wr_req && pr_wr_gnt, else 0.
- Pop:
  - Occurs when pr_wr_req && pr_wr_gnt; rptr advances modulo DEPTH.
  - Exactly one write per cycle. Order is strictly FIFO, including writes to different warps.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Latency (feature off): a result pushed at edge N is written no earlier than the cycle after N, i.e. the first pr_wr_gnt seen after N.
- Hazard query:
  - hz_pending = OR over valid entries of (entry.warp == hz_warp && entry.preg == hz_preg). Combinational.
  - Covers queued entries only. A result being pushed in the current cycle is visible from the next cycle.
  - An entry being popped this cycle still reports pending this cycle.
- Two queued writes to the same (warp, preg) are both issued in order, so the later write wins per lane. No coalescing.
- pr_wr_gnt while empty: no effect; pr_write_en = 0.

Optional Feature:
PRED_WB_BYPASS_EN
- Defined: when count == 0, in_valid=1, in_mask != 0 and pr_wr_gnt=1, the input drives the pr_* outputs directly.
  - pr_wr_req = 1, pr_write_en = in_mask.
  - The write happens in the same cycle and the entry is not enqueued (zero-latency writeback).
  - hz_pending does not report the bypassed write.
- Undefined: no bypass; minimum one-cycle latency through the FIFO as described under Behaviour.

Test Plan:
1. Reset then idle:
   - rst=1 for 2 cycles -> in_ready=1, pr_wr_req=0, pr_write_en=16'h0000, count=0, hz_pending=0.
2. Single write:
   - Push warp=3, preg=5, mask=16'hFFFF, data=16'hA5A5; pr_wr_gnt=1 the next cycle.
   - Required: pr_write_en=16'hFFFF, pr_waddr=5, pr_warp_selector=3, pr_wdata=16'hA5A5 for exactly one cycle, then count=0.
   - Register block read of warp 3 reg 5 returns rdata lane i = bit i of 16'hA5A5.
3. Fill and backpressure:
   - Push 4 results with pr_wr_gnt=0 -> count=4, in_ready=0.
   - A 5th in_valid is not accepted.
   - Raise pr_wr_gnt -> writes drain in push order, one per cycle; in_ready=1 in the cycle after the first pop.
4. Hazard query:
   - Queue warp=7, preg=2 with pr_wr_gnt=0; query (7,2) -> hz_pending=1; query (7,3) -> 0.
   - After the pop cycle, query (7,2) -> 0.
5. Mask handling:
   - Push mask=16'h0000 -> count stays 0, no write.
   - Push mask=16'h00F0, data=16'hFFFF -> pr_write_en=16'h00F0 on grant; lanes outside bits 4..7 are unchanged in the register block.
6. Stress and reset:
   - Simultaneous push and pop for 20 cycles with random warp/preg -> count constant, write order matches push order across the pointer wrap.
   - Assert rst with count=3 -> next cycle count=0, pr_wr_req=0, no writes issued.
   - With PRED_WB_BYPASS_EN: empty FIFO, in_valid with pr_wr_gnt=1 -> pr_write_en=in_mask in the same cycle, count stays 0.
